// File: rtl/exe_pkg.sv
// Shared execute-stage types: op encodings, FSM states, divider fix-up context and op classification helpers.
package exe_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned IMM_W = 20;
  localparam int unsigned WLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 6'd0,
    OP_SUB    = 6'd1,
    OP_SLL    = 6'd2,
    OP_SLT    = 6'd3,
    OP_SLTU   = 6'd4,
    OP_XOR    = 6'd5,
    OP_SRL    = 6'd6,
    OP_SRA    = 6'd7,
    OP_OR     = 6'd8,
    OP_AND    = 6'd9,
    OP_MUL    = 6'd10,
    OP_MULH   = 6'd11,
    OP_MULHSU = 6'd12,
    OP_MULHU  = 6'd13,
    OP_DIV    = 6'd14,
    OP_DIVU   = 6'd15,
    OP_REM    = 6'd16,
    OP_REMU   = 6'd17,
    OP_ADDW   = 6'd18,
    OP_SUBW   = 6'd19,
    OP_SLLW   = 6'd20,
    OP_SRLW   = 6'd21,
    OP_SRAW   = 6'd22,
    OP_MULW   = 6'd23,
    OP_DIVW   = 6'd24,
    OP_DIVUW  = 6'd25,
    OP_REMW   = 6'd26,
    OP_REMUW  = 6'd27
  } exe_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DIV_FIX = 2'd2,
    OUT     = 2'd3
  } exe_state_e;

  // Sign/selection context carried from accept to the divider fix-up cycle.
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic sel_rem;
    logic word;
  } div_ctl_t;

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_word(input logic [OP_W-1:0] op);
    return op inside {OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
                      OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem(input logic [OP_W-1:0] op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_signed_div(input logic [OP_W-1:0] op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] x);
    return {{(XLEN-WLEN){x[WLEN-1]}}, x};
  endfunction

endpackage

// File: rtl/exe_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle, 32 or 64 iterations.
module exe_divider
  import exe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done_c
);

  localparam int unsigned CNT_W = 7;

  logic [CNT_W-1:0] cnt;
  logic             active;
  logic [XLEN-1:0]  dvsr;
  logic [XLEN:0]    rem_sh;
  logic [XLEN-1:0]  diff;
  logic             ge;

  // Trial subtraction; the difference only matters when it is non-negative, so XLEN bits suffice.
  always_comb begin
    rem_sh = {remainder, quotient[XLEN-1]};
    ge     = (rem_sh >= {1'b0, dvsr});
    diff   = rem_sh[XLEN-1:0] - dvsr;
  end

  assign done_c = active && (cnt == '0);

  // Word mode parks the 32-bit dividend in the top half so the same shift path serves both widths.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      cnt       <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      active    <= 1'b1;
      cnt       <= word ? CNT_W'(WLEN - 1) : CNT_W'(XLEN - 1);
      dvsr      <= divisor;
      remainder <= '0;
      quotient  <= word ? {dividend[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dividend;
    end else if (active) begin
      remainder <= ge ? diff : rem_sh[XLEN-1:0];
      quotient  <= {quotient[XLEN-2:0], ge};
      cnt       <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/shift/compare/multiply, iterative DIV/REM, valid/ready on both sides.
module exec_unit
  import exe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic [REG_W-1:0]  rd_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  out_rd_idx,
  output logic [XLEN-1:0]   out_result,
  output logic              busy
);

  exe_state_e       state, state_d;
  logic             accept;
  logic [XLEN-1:0]  opb;
  logic [5:0]       shamt;
  logic [4:0]       shamt_w;

  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              mul_sa, mul_sb;

  logic             word, sgn, a_neg, b_neg;
  logic             div_zero, div_ovf, div_special;
  logic [WLEN-1:0]  mag_a_w, mag_b_w;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN-1:0]  fast_res;

  div_ctl_t         ctl, ctl_d;
  logic             div_start, div_done_c;
  logic [XLEN-1:0]  quotient, remainder;
  logic [XLEN-1:0]  q_fix, r_fix, fix_sel, fix_res;

  logic             valid_d, busy_d;
  logic [XLEN-1:0]  result_d;
  logic [REG_W-1:0] rd_d;

  assign opb      = use_imm ? {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm} : rs2_val;
  assign shamt    = opb[5:0];
  assign shamt_w  = opb[4:0];
  assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);
  assign accept   = in_valid && in_ready;

  // One full-width multiplier; sign extension of each operand selects the MULH flavour.
  always_comb begin
    mul_sa = (op == OP_MULH) || (op == OP_MULHSU);
    mul_sb = (op == OP_MULH);
    mul_a  = {{XLEN{mul_sa & rs1_val[XLEN-1]}}, rs1_val};
    mul_b  = {{XLEN{mul_sb & opb[XLEN-1]}}, opb};
    prod   = mul_a * mul_b;
  end

  // Divider operand preparation and the two short-circuit cases.
  always_comb begin
    word     = is_word(op);
    sgn      = is_signed_div(op);
    a_neg    = sgn & (word ? rs1_val[WLEN-1] : rs1_val[XLEN-1]);
    b_neg    = sgn & (word ? opb[WLEN-1] : opb[XLEN-1]);
    div_zero = word ? (opb[WLEN-1:0] == '0) : (opb == '0);
    div_ovf  = sgn & (word ? ((rs1_val[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}}) && (opb[WLEN-1:0] == '1))
                           : ((rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1)));
    div_special = div_zero | div_ovf;
    mag_a_w  = a_neg ? -rs1_val[WLEN-1:0] : rs1_val[WLEN-1:0];
    mag_b_w  = b_neg ? -opb[WLEN-1:0] : opb[WLEN-1:0];
    mag_a    = word ? {{(XLEN-WLEN){1'b0}}, mag_a_w} : (a_neg ? -rs1_val : rs1_val);
    mag_b    = word ? {{(XLEN-WLEN){1'b0}}, mag_b_w} : (b_neg ? -opb : opb);
  end

  // Single-cycle result, including the divide-by-zero and overflow short cuts.
  always_comb begin
    fast_res = '0;
    case (op)
      OP_ADD:    fast_res = rs1_val + opb;
      OP_SUB:    fast_res = rs1_val - opb;
      OP_SLL:    fast_res = rs1_val << shamt;
      OP_SLT:    fast_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(opb)};
      OP_SLTU:   fast_res = {{(XLEN-1){1'b0}}, rs1_val < opb};
      OP_XOR:    fast_res = rs1_val ^ opb;
      OP_SRL:    fast_res = rs1_val >> shamt;
      OP_SRA:    fast_res = $signed(rs1_val) >>> shamt;
      OP_OR:     fast_res = rs1_val | opb;
      OP_AND:    fast_res = rs1_val & opb;
      OP_MUL:    fast_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:
                 fast_res = prod[2*XLEN-1:XLEN];
      OP_ADDW:   fast_res = sext_w(rs1_val[WLEN-1:0] + opb[WLEN-1:0]);
      OP_SUBW:   fast_res = sext_w(rs1_val[WLEN-1:0] - opb[WLEN-1:0]);
      OP_SLLW:   fast_res = sext_w(rs1_val[WLEN-1:0] << shamt_w);
      OP_SRLW:   fast_res = sext_w(rs1_val[WLEN-1:0] >> shamt_w);
      OP_SRAW:   fast_res = sext_w($signed(rs1_val[WLEN-1:0]) >>> shamt_w);
      OP_MULW:   fast_res = sext_w(prod[WLEN-1:0]);
      OP_DIV, OP_DIVU:   fast_res = div_zero ? '1 : rs1_val;
      OP_REM, OP_REMU:   fast_res = div_zero ? rs1_val : '0;
      OP_DIVW, OP_DIVUW: fast_res = div_zero ? '1 : sext_w(rs1_val[WLEN-1:0]);
      OP_REMW, OP_REMUW: fast_res = div_zero ? sext_w(rs1_val[WLEN-1:0]) : '0;
      default:   fast_res = '0;
    endcase
  end

  exe_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .word      (word),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder),
    .done_c    (div_done_c)
  );

  // Sign restoration and width selection after the magnitude divide.
  always_comb begin
    q_fix   = ctl.neg_q ? -quotient : quotient;
    r_fix   = ctl.neg_r ? -remainder : remainder;
    fix_sel = ctl.sel_rem ? r_fix : q_fix;
    fix_res = ctl.word ? sext_w(fix_sel[WLEN-1:0]) : fix_sel;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state;
    valid_d   = out_valid;
    result_d  = out_result;
    rd_d      = out_rd_idx;
    ctl_d     = ctl;
    div_start = 1'b0;
    case (state)
      IDLE, OUT: begin
        if ((state == OUT) && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        if (accept) begin
          rd_d = rd_idx;
          if (is_div(op) && !div_special) begin
            state_d       = DIV_RUN;
            valid_d       = 1'b0;
            div_start     = 1'b1;
            ctl_d.neg_q   = a_neg ^ b_neg;
            ctl_d.neg_r   = a_neg;
            ctl_d.sel_rem = is_rem(op);
            ctl_d.word    = word;
          end else begin
            state_d  = OUT;
            valid_d  = 1'b1;
            result_d = fast_res;
          end
        end
      end
      DIV_RUN: begin
        if (div_done_c) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d  = OUT;
        valid_d  = 1'b1;
        result_d = fix_res;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DIV_RUN) || (state_d == DIV_FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd_idx <= '0;
      busy       <= 1'b0;
      ctl        <= '0;
    end else begin
      state      <= state_d;
      out_valid  <= valid_d;
      out_result <= result_d;
      out_rd_idx <= rd_d;
      busy       <= busy_d;
      ctl        <= ctl_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed and randomized checks of exec_unit against an arithmetic reference model.
module tb_exec_unit;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op = '0;
  logic [63:0] rs1_val = '0;
  logic [63:0] rs2_val = '0;
  logic [19:0] imm = '0;
  logic        use_imm = 1'b0;
  logic [4:0]  rd_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd_idx;
  logic [63:0] out_result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  exec_unit dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .imm        (imm),
    .use_imm    (use_imm),
    .rd_idx     (rd_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd_idx (out_rd_idx),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference result and latency straight from the arithmetic definition of each op.
  function automatic logic [63:0] ref_result(input logic [5:0] o, input logic [63:0] a,
                                              input logic [63:0] b, output int lat);
    longint sa, sb;
    int a32, b32;
    logic [31:0] ua32, ub32;
    logic signed [127:0] pa, pb, pp;
    logic [63:0] r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    lat = 1; r = '0; pa = '0; pb = '0;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << b[5:0];
      OP_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU: r = (a < b) ? 64'd1 : 64'd0;
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> b[5:0];
      OP_SRA:  r = sa >>> b[5:0];
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_MUL:  r = a * b;
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        if (o == OP_MULHU) pa = {64'd0, a}; else pa = sa;
        if (o == OP_MULH)  pb = sb;         else pb = {64'd0, b};
        pp = pa * pb;
        r = pp[127:64];
      end
      OP_DIV:  if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
               else begin r = sa / sb; lat = 66; end
      OP_REM:  if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0;
               else begin r = sa % sb; lat = 66; end
      OP_DIVU: if (b == 0) r = '1; else begin r = a / b; lat = 66; end
      OP_REMU: if (b == 0) r = a;  else begin r = a % b; lat = 66; end
      OP_ADDW: r = sx32(a32 + b32);
      OP_SUBW: r = sx32(a32 - b32);
      OP_SLLW: r = sx32(ua32 << b[4:0]);
      OP_SRLW: r = sx32(ua32 >> b[4:0]);
      OP_SRAW: r = sx32(a32 >>> b[4:0]);
      OP_MULW: r = sx32(a32 * b32);
      OP_DIVW: if (b32 == 0) r = '1; else if (ua32 == 32'h8000_0000 && b32 == -1) r = sx32(ua32);
               else begin r = sx32(a32 / b32); lat = 34; end
      OP_REMW: if (b32 == 0) r = sx32(ua32); else if (ua32 == 32'h8000_0000 && b32 == -1) r = 0;
               else begin r = sx32(a32 % b32); lat = 34; end
      OP_DIVUW: if (ub32 == 0) r = '1; else begin r = sx32(ua32 / ub32); lat = 34; end
      OP_REMUW: if (ub32 == 0) r = sx32(ua32); else begin r = sx32(ua32 % ub32); lat = 34; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [5:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [19:0] im, input logic ui, input logic [4:0] rd);
    op = o; rs1_val = a; rs2_val = b; imm = im; use_imm = ui; rd_idx = rd; in_valid = 1'b1;
  endtask

  // Issue one op with writeback always ready, then check result, index, latency and stall behaviour.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [19:0] im, input logic ui,
                        input logic [4:0] rd, input logic [63:0] exp_res, input int exp_lat);
    int lat, busy_cnt, ready_err;
    lat = 0; busy_cnt = 0; ready_err = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drive(o, a, b, im, ui, rd);
    check({tag, "_inready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (!out_valid && in_ready) ready_err++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_rd"}, 64'(out_rd_idx), 64'(rd));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), (exp_lat > 1) ? 64'(exp_lat - 1) : 64'd0);
    check({tag, "_stall"}, 64'(ready_err), 64'd0);
  endtask

  initial begin
    int lat, stale;
    logic [5:0] o;
    logic [63:0] a, b, beff, exp;
    logic [19:0] im;
    logic ui;
    logic [4:0] rd;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_result", out_result, 64'd0);
    check("reset_rd", 64'(out_rd_idx), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_inready", 64'(in_ready), 64'd1);

    run_op("add", OP_ADD, 64'd5, -64'sd3, 20'd0, 1'b0, 5'd7, 64'd2, 1);
    run_op("addi", OP_ADD, 64'h10, 64'd0, 20'hFFFFF, 1'b1, 5'd1, 64'hF, 1);
    run_op("addw", OP_ADDW, 64'h7FFF_FFFF, 64'd0, 20'd1, 1'b1, 5'd2, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("div", OP_DIV, -64'sd7, 64'd2, 20'd0, 1'b0, 5'd3, -64'sd3, 66);
    run_op("rem", OP_REM, -64'sd7, 64'd2, 20'd0, 1'b0, 5'd4, '1, 66);
    run_op("divu_z", OP_DIVU, 64'd123, 64'd0, 20'd0, 1'b0, 5'd5, '1, 1);
    run_op("rem_z", OP_REM, 64'd9, 64'd0, 20'd0, 1'b0, 5'd6, 64'd9, 1);
    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 20'd0, 1'b0, 5'd8,
           64'h8000_0000_0000_0000, 1);
    run_op("divw", OP_DIVW, 64'd100, -64'sd7, 20'd0, 1'b0, 5'd9, -64'sd14, 34);
    run_op("undef", 6'd45, 64'd77, 64'd3, 20'd0, 1'b0, 5'd10, 64'd0, 1);

    // Writeback stall with two further ops queued behind the first.
    @(negedge clk);
    out_ready = 1'b0;
    drive(OP_ADD, 64'd100, 64'd1, 20'd0, 1'b0, 5'd11);
    check("bp_ready_first", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 drive(OP_ADD, 64'd200, 64'd2, 20'd0, 1'b0, 5'd12);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold_result%0d", k), out_result, 64'd101);
      check($sformatf("bp_hold_rd%0d", k), 64'(out_rd_idx), 64'd11);
      check($sformatf("bp_hold_inready%0d", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("bp_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 drive(OP_ADD, 64'd300, 64'd3, 20'd0, 1'b0, 5'd13);
    @(negedge clk);
    check("bp_drain2_valid", 64'(out_valid), 64'd1);
    check("bp_drain2_result", out_result, 64'd202);
    check("bp_drain2_rd", 64'(out_rd_idx), 64'd12);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain3_valid", 64'(out_valid), 64'd1);
    check("bp_drain3_result", out_result, 64'd303);
    check("bp_drain3_rd", 64'(out_rd_idx), 64'd13);
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Reset in the middle of a word division.
    @(negedge clk);
    drive(OP_DIVW, 64'd1000, 64'd7, 20'd0, 1'b0, 5'd9);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_busy_clr", 64'(busy), 64'd0);
    check("rst_mid_inready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);
    run_op("rst_add", OP_ADD, 64'd40, 64'd2, 20'd0, 1'b0, 5'd3, 64'd42, 1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 80; i++) begin
      o  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(28, 63)) : 6'($urandom_range(0, 27));
      a  = rand_val();
      b  = rand_val();
      im = 20'($urandom);
      ui = ($urandom_range(0, 3) == 0);
      rd = 5'($urandom);
      beff = ui ? {{44{im[19]}}, im} : b;
      exp = ref_result(o, a, beff, lat);
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, im, ui, rd, exp, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
